// File: rtl/encrypt_sched_pkg.sv
// Shared types for the encrypt_unit session scheduler: per-requester
// configuration word, scheduler FSM states and the default burst limit.
package encrypt_config;

  localparam int SCHED_MAX_BURST = 16;

  typedef struct packed {
    logic [7:0] k1;
    logic [7:0] k2;
    logic [7:0] k3;
    logic [2:0] rot_freq;
    logic       shift_en;
    logic [2:0] shift_amt;
    logic       mode;
  } enc_cfg_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    BURST = 2'd2,
    DRAIN = 2'd3
  } sched_state_t;

endpackage

// File: rtl/encrypt_sched_arb.sv
// Round-robin pick: first requester at or after ptr_i, wrapping; purely combinational.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_id_o,
  output logic            any_o
);

  logic [IDW-1:0] idx;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    any_o    = 1'b0;
    idx      = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = IDW'((int'(ptr_i) + off) % NREQ);
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_id_o   = idx;
        gnt_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encrypt_sched.sv
// Shares one encrypt_unit between NREQ byte streams, one session (burst) at a time,
// resetting the unit before each session and draining it before changing owner.
module encrypt_sched
  import encrypt_config::*;
#(
  parameter  int NREQ      = 2,
  parameter  int PIPE_LAT  = 2,
  parameter  int MAX_BURST = SCHED_MAX_BURST,
  localparam int IDW       = $clog2(NREQ),
  localparam int BW        = $clog2(MAX_BURST),
  localparam int OW        = $clog2(PIPE_LAT + 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0][7:0] req_din,
  input  logic [NREQ-1:0]      req_last,
  input  enc_cfg_t [NREQ-1:0]  req_cfg,
  output logic [NREQ-1:0]      req_ready,
  output logic                 eu_rst,
  output logic                 eu_en,
  output logic [7:0]           eu_din,
  output logic [7:0]           eu_k1,
  output logic [7:0]           eu_k2,
  output logic [7:0]           eu_k3,
  output logic [2:0]           eu_rot_freq,
  output logic [2:0]           eu_shift_amt,
  output logic                 eu_shift_en,
  output logic                 eu_mode,
  input  logic                 eu_v,
  input  logic [7:0]           eu_dout,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  output logic [IDW-1:0]       out_id,
  output logic                 out_last,
  output logic                 err
);

  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
  localparam logic [OW-1:0] OUT_MAX   = '1;

  sched_state_t   state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  enc_cfg_t       cfg_q, cfg_d, cfg_sel;
  logic [BW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [OW-1:0]  outst_q, outst_d;
  logic           err_q, err_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_id;
  logic            arb_any;
  logic            hs;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i    (req_valid),
    .ptr_i    (rr_ptr_q),
    .gnt_o    (arb_gnt),
    .gnt_id_o (arb_id),
    .any_o    (arb_any)
  );

  always_comb begin
    cfg_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) cfg_sel = req_cfg[i];
    end
  end

  // Datapath outputs are gated by rst so an abandoned session cannot leak a beat.
  always_comb begin
    hs        = 1'b0;
    req_ready = '0;
    eu_en     = 1'b0;
    eu_din    = '0;
    if (!rst && state_q == BURST) begin
      req_ready[gnt_id_q] = 1'b1;
      hs                  = req_valid[gnt_id_q];
    end
    if (hs) begin
      eu_en  = 1'b1;
      eu_din = req_din[gnt_id_q];
    end
  end

  assign out_valid = !rst && eu_v && (outst_q != '0);
  assign out_data  = eu_dout;
  assign out_id    = gnt_id_q;
  assign out_last  = out_valid && (state_q == DRAIN) && (outst_q == OW'(1));
  assign err       = err_q;

  assign eu_rst       = ~(rst | (state_q == LOAD));
  assign eu_k1        = cfg_q.k1;
  assign eu_k2        = cfg_q.k2;
  assign eu_k3        = cfg_q.k3;
  assign eu_rot_freq  = cfg_q.rot_freq;
  assign eu_shift_amt = cfg_q.shift_amt;
  assign eu_shift_en  = cfg_q.shift_en;
  assign eu_mode      = cfg_q.mode;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_id_d   = gnt_id_q;
    cfg_d      = cfg_q;
    beat_cnt_d = beat_cnt_q;
    outst_d    = outst_q;
    err_d      = err_q | (eu_v && (outst_q == '0));

    if (hs && !out_valid && outst_q != OUT_MAX) outst_d = outst_q + OW'(1);
    else if (!hs && out_valid)                  outst_d = outst_q - OW'(1);
    if (hs) beat_cnt_d = beat_cnt_q + BW'(1);

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          gnt_id_d = arb_id;
          cfg_d    = cfg_sel;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        beat_cnt_d = '0;
        state_d    = BURST;
      end
      BURST: begin
        if (hs && (req_last[gnt_id_q] || beat_cnt_q == BEAT_LAST)) state_d = DRAIN;
      end
      DRAIN: begin
        if (outst_d == '0) begin
          state_d  = IDLE;
          rr_ptr_d = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + IDW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gnt_id_q   <= '0;
      cfg_q      <= '0;
      beat_cnt_q <= '0;
      outst_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_id_q   <= gnt_id_d;
      cfg_q      <= cfg_d;
      beat_cnt_q <= beat_cnt_d;
      outst_q    <= outst_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_encrypt_sched.sv
// Directed bench for encrypt_sched with a simple keyed encrypt_unit model:
// dout = din ^ k1 ^ ks, ks starts at 0 after eu_rst and advances by k2 per byte.
module tb_encrypt_sched;
  import encrypt_config::*;

  localparam int NREQ      = 2;
  localparam int PIPE_LAT  = 2;
  localparam int MAX_BURST = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid, req_last, req_ready;
  logic [NREQ-1:0][7:0] req_din;
  enc_cfg_t [NREQ-1:0]  req_cfg;
  logic                 eu_rst, eu_en;
  logic [7:0]           eu_din, eu_k1, eu_k2, eu_k3;
  logic [2:0]           eu_rot_freq, eu_shift_amt;
  logic                 eu_shift_en, eu_mode;
  logic                 eu_v;
  logic [7:0]           eu_dout;
  logic                 out_valid, out_last, err;
  logic [7:0]           out_data;
  logic [0:0]           out_id;

  always #5 clk = ~clk;

  encrypt_sched #(.NREQ(NREQ), .PIPE_LAT(PIPE_LAT), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_din(req_din), .req_last(req_last), .req_cfg(req_cfg),
    .req_ready(req_ready),
    .eu_rst(eu_rst), .eu_en(eu_en), .eu_din(eu_din),
    .eu_k1(eu_k1), .eu_k2(eu_k2), .eu_k3(eu_k3),
    .eu_rot_freq(eu_rot_freq), .eu_shift_amt(eu_shift_amt),
    .eu_shift_en(eu_shift_en), .eu_mode(eu_mode),
    .eu_v(eu_v), .eu_dout(eu_dout),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .out_last(out_last), .err(err)
  );

  // encrypt_unit stand-in
  logic [PIPE_LAT-1:0] pv;
  logic [7:0]          pd [PIPE_LAT];
  logic [7:0]          ks;
  logic                spur = 1'b0;

  always @(posedge clk) begin
    if (!eu_rst) begin
      pv <= '0;
      ks <= '0;
    end else begin
      pv    <= {pv[PIPE_LAT-2:0], eu_en};
      pd[0] <= eu_din ^ eu_k1 ^ ks;
      for (int i = 1; i < PIPE_LAT; i++) pd[i] <= pd[i-1];
      if (eu_en) ks <= ks + eu_k2;
    end
  end

  assign eu_v    = pv[PIPE_LAT-1] | spur;
  assign eu_dout = pd[PIPE_LAT-1];

  // requester drivers: entries are {last, byte}
  logic [8:0]      tx0[$];
  logic [8:0]      tx1[$];
  int              gap_cfg = 0;
  int              gap_cnt [NREQ];
  logic [NREQ-1:0] hs_seen = '0;

  initial begin
    logic [8:0] h;
    bit nz;
    req_valid = '0;
    req_din   = '0;
    req_last  = '0;
    h         = '0;
    for (int r = 0; r < NREQ; r++) gap_cnt[r] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int r = 0; r < NREQ; r++) begin
        if (hs_seen[r]) begin
          if (r == 0 && tx0.size() > 0) void'(tx0.pop_front());
          if (r == 1 && tx1.size() > 0) void'(tx1.pop_front());
          gap_cnt[r] = gap_cfg;
        end
        nz = (r == 0) ? (tx0.size() > 0) : (tx1.size() > 0);
        if (nz) h = (r == 0) ? tx0[0] : tx1[0];
        if (gap_cnt[r] > 0) begin
          req_valid[r] = 1'b0;
          gap_cnt[r]--;
        end else if (nz) begin
          req_valid[r] = 1'b1;
          req_din[r]   = h[7:0];
          req_last[r]  = h[8];
        end else begin
          req_valid[r] = 1'b0;
          req_last[r]  = 1'b0;
        end
      end
    end
  end

  // monitor: results {id, last, data} and a few running counters
  logic [9:0] rx[$];
  int cyc = 0, t_v = -1, t_r = -1, rstlo = 0, en_cnt = 0, en_bad = 0, of = 0, of_max = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    hs_seen = req_valid & req_ready;
    if (rst) begin
      of = 0;
    end else begin
      if (out_valid) rx.push_back({out_id, out_last, out_data});
      if (!eu_rst) rstlo++;
      if (eu_en) en_cnt++;
      if (eu_en !== |(req_valid & req_ready)) en_bad++;
      of = of + int'(eu_en) - int'(pv[PIPE_LAT-1]);
      if (of > of_max) of_max = of;
      if (t_v < 0 && req_valid[0]) t_v = cyc;
      if (t_r < 0 && req_ready[0]) t_r = cyc;
    end
  end

  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rx(input string tag, input int idx, input logic id, input logic last,
                        input logic [7:0] data);
    logic [9:0] got;
    got = (idx < rx.size()) ? rx[idx] : 10'bx;
    chk(tag, 32'(got), 32'({id, last, data}));
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    int k = 0;
    while (rx.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(tag, rx.size(), n);
  endtask

  function automatic enc_cfg_t mkcfg(input logic [7:0] k1, input logic [7:0] k2,
                                     input logic [7:0] k3, input logic [2:0] rot,
                                     input logic shen, input logic [2:0] amt, input logic md);
    enc_cfg_t c;
    c.k1 = k1; c.k2 = k2; c.k3 = k3;
    c.rot_freq = rot; c.shift_en = shen; c.shift_amt = amt; c.mode = md;
    return c;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [7:0] e;
    rst     = 1'b1;
    req_cfg = '0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_eu_en", 32'(eu_en), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_eu_rst_low", 32'(eu_rst), 0);
    chk("rst_cfg_regs", 32'({eu_k1, eu_k2, eu_k3, eu_rot_freq, eu_shift_en, eu_shift_amt, eu_mode}), 0);

    // single requester, 3 bytes
    req_cfg[0] = mkcfg(8'hA5, 8'h01, 8'h3C, 3'd5, 1'b1, 3'd3, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_no_ready", 32'(req_ready), 0);
    chk("idle_eu_rst_high", 32'(eu_rst), 1);
    rstlo = 0; t_v = -1; t_r = -1;
    tx0.push_back({1'b0, 8'h11});
    tx0.push_back({1'b0, 8'h22});
    tx0.push_back({1'b1, 8'h33});
    wait_rx("t1_count", 3, 40);
    chk("t1_grant_latency", 32'(t_r - t_v), 2);
    chk_rx("t1_r0", 0, 1'b0, 1'b0, 8'hB4);
    chk_rx("t1_r1", 1, 1'b0, 1'b0, 8'h86);
    chk_rx("t1_r2", 2, 1'b0, 1'b1, 8'h94);
    chk("t1_eu_rst_pulses", 32'(rstlo), 1);
    chk("t1_cfg_out", 32'({eu_k1, eu_k3, eu_rot_freq, eu_shift_en, eu_shift_amt, eu_mode}),
        32'({8'hA5, 8'h3C, 3'd5, 1'b1, 3'd3, 1'b1}));
    repeat (4) @(negedge clk);

    // both requesters valid at reset release
    #1;
    rst = 1'b1;
    rx.delete();
    req_cfg[0] = mkcfg(8'h10, 8'h02, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0);
    req_cfg[1] = mkcfg(8'h20, 8'h03, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0);
    tx0.push_back({1'b0, 8'h01});
    tx0.push_back({1'b1, 8'h02});
    tx1.push_back({1'b0, 8'h03});
    tx1.push_back({1'b0, 8'h04});
    tx1.push_back({1'b1, 8'h05});
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    rstlo = 0;
    wait_rx("t2_count", 5, 60);
    chk_rx("t2_r0", 0, 1'b0, 1'b0, 8'h11);
    chk_rx("t2_r1", 1, 1'b0, 1'b1, 8'h10);
    chk_rx("t2_r2", 2, 1'b1, 1'b0, 8'h23);
    chk_rx("t2_r3", 3, 1'b1, 1'b0, 8'h27);
    chk_rx("t2_r4", 4, 1'b1, 1'b1, 8'h23);
    chk("t2_eu_rst_pulses", 32'(rstlo), 2);
    tx0.push_back({1'b1, 8'hFF});
    tx1.push_back({1'b1, 8'h00});
    wait_rx("t2b_count", 7, 60);
    chk_rx("t2b_r5", 5, 1'b0, 1'b1, 8'hEF);
    chk_rx("t2b_r6", 6, 1'b1, 1'b1, 8'h20);
    repeat (4) @(negedge clk);

    // 20-byte stream split at MAX_BURST
    #1;
    rx.delete();
    rstlo = 0;
    req_cfg[0] = mkcfg(8'h5A, 8'h01, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0);
    for (int i = 1; i <= 20; i++) tx0.push_back({(i == 20), 8'(i)});
    wait_rx("t3_count", 20, 200);
    for (int j = 0; j < 20; j++) begin
      e = 8'(j + 1) ^ 8'h5A ^ 8'((j < MAX_BURST) ? j : j - MAX_BURST);
      chk_rx($sformatf("t3_r%0d", j), j, 1'b0, (j == 15 || j == 19), e);
    end
    chk("t3_split_fresh_key", 32'(rx[16][7:0]), 32'h4B);
    chk("t3_eu_rst_pulses", 32'(rstlo), 2);
    repeat (4) @(negedge clk);

    // gaps of 3 cycles between beats
    #1;
    rx.delete();
    en_cnt = 0; en_bad = 0; of_max = 0;
    gap_cfg = 3;
    req_cfg[1] = mkcfg(8'h33, 8'h04, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0);
    tx1.push_back({1'b0, 8'hA0});
    tx1.push_back({1'b0, 8'hA1});
    tx1.push_back({1'b0, 8'hA2});
    tx1.push_back({1'b1, 8'hA3});
    wait_rx("t4_count", 4, 100);
    chk_rx("t4_r0", 0, 1'b1, 1'b0, 8'h93);
    chk_rx("t4_r1", 1, 1'b1, 1'b0, 8'h96);
    chk_rx("t4_r2", 2, 1'b1, 1'b0, 8'h99);
    chk_rx("t4_r3", 3, 1'b1, 1'b1, 8'h9C);
    chk("t4_en_pulses", 32'(en_cnt), 4);
    chk("t4_en_only_on_hs", 32'(en_bad), 0);
    chk("t4_inflight_bound", 32'(of_max <= PIPE_LAT), 1);
    gap_cfg = 0;
    repeat (4) @(negedge clk);

    // reset during BURST with two bytes in flight
    #1;
    rx.delete();
    en_cnt = 0;
    req_cfg[0] = mkcfg(8'h77, 8'h00, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 6; i++) tx0.push_back({(i == 5), 8'(8'h10 + i)});
    k = 0;
    while (en_cnt < 2 && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("t5_two_in_flight", 32'(en_cnt), 2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    tx0.delete();
    req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("t5_no_out_valid", 32'(rx.size()), 0);
    chk("t5_err_clear", 32'(err), 0);
    chk("t5_idle_no_ready", 32'(req_ready), 0);
    req_cfg[0] = mkcfg(8'h77, 8'h10, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0);
    tx0.push_back({1'b0, 8'h01});
    tx0.push_back({1'b1, 8'h02});
    wait_rx("t5_count", 2, 40);
    chk_rx("t5_r0", 0, 1'b0, 1'b0, 8'h76);
    chk_rx("t5_r1", 1, 1'b0, 1'b1, 8'h65);
    chk("t5_err_after", 32'(err), 0);
    repeat (4) @(negedge clk);

    // spurious eu_v in IDLE
    #1;
    rx.delete();
    spur = 1'b1;
    #1;
    chk("t6_spur_not_forwarded", 32'(out_valid), 0);
    @(negedge clk);
    #1;
    spur = 1'b0;
    chk("t6_err_set", 32'(err), 1);
    repeat (5) @(negedge clk);
    #1;
    chk("t6_err_sticky", 32'(err), 1);
    chk("t6_no_results", 32'(rx.size()), 0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("t6_err_cleared_by_rst", 32'(err), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/encrypt_sched.md
# encrypt_sched

Session scheduler that shares one `encrypt_unit` (configurable mode) between `NREQ` byte-stream requesters. It arbitrates round-robin at session (burst) granularity and loads the winner's key/rotation/shift configuration. Before each session it pulses the unit's reset so every session starts from a fresh key state. It drains the unit's pipeline before switching owner, and returns results tagged with requester ID and end-of-burst.

## Interface
Parameters:
- `NREQ`, 2, number of requesters (2..4)
- `PIPE_LAT`, 2, cycles from `eu_en` to the matching `eu_v`
- `MAX_BURST`, 16, maximum beats per session; longer streams are split

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NREQ  per-requester byte valid
- `req_din`  in  NREQ x 8  per-requester plaintext byte
- `req_last`  in  NREQ  marks final byte of a requester's stream
- `req_cfg`  in  NREQ x enc_cfg_t  per-requester configuration; sampled at grant
- `req_ready`  out  NREQ  byte accepted when `req_valid & req_ready`
- `eu_rst`  out  1  active-low reset to encrypt_unit
- `eu_en`, `eu_din[7:0]`  out  1, 8  data strobe and byte to encrypt_unit
- `eu_k1`, `eu_k2`, `eu_k3` [7:0]; `eu_rot_freq`, `eu_shift_amt` [2:0]; `eu_shift_en`, `eu_mode`  out  configuration to encrypt_unit, held stable for the whole session
- `eu_v`, `eu_dout[7:0]`  in  1, 8  result from encrypt_unit
- `out_valid`, `out_data[7:0]`  out  1, 8  ciphertext byte (no backpressure)
- `out_id`  out  $clog2(NREQ)  owner of `out_data`
- `out_last`  out  1  final result of the current session
- `err`  out  1  sticky; set when `eu_v` arrives with no result outstanding

## Operation
- FSM has four states: IDLE, LOAD, BURST, DRAIN.
- IDLE: if any `req_valid`, grant the first requester at or after `rr_ptr`, wrapping around. Latch `gnt_id` and `req_cfg[gnt_id]` into the configuration registers, then go to LOAD.
- LOAD, one cycle: `eu_rst`=0 to reset the key state. Go to BURST.
- BURST:
  - `req_ready[gnt_id] = 1`; all other `req_ready` bits are 0.
  - On each handshake, `eu_en`=1 and `eu_din=req_din[gnt_id]`. `beat_cnt` and `outstanding` both increment.
  - The cycle after a handshake with `req_last`, or with `beat_cnt==MAX_BURST-1`, the FSM goes to DRAIN.
  - If `req_valid` drops, the session stalls with no timeout.
- DRAIN: `req_ready`=0. When `outstanding` reaches 0, go to IDLE with `rr_ptr = gnt_id+1` mod NREQ.
- Results:
  - `out_valid = eu_v & (outstanding!=0)`, `out_data = eu_dout`, `out_id = gnt_id`.
  - Each `eu_v` decrements `outstanding`.
  - `out_last = out_valid & state==DRAIN & outstanding==1`.
- Split streams: a stream truncated at MAX_BURST gets `out_last` at the split point. Its remainder is re-arbitrated as a new session with a fresh key state.
- Width rules:
  - `beat_cnt` is $clog2(MAX_BURST) bits and clears in LOAD.
  - `outstanding` is $clog2(PIPE_LAT+2) bits and never wraps. Increment and decrement in the same cycle leaves it unchanged.
- `eu_v` with `outstanding==0` sets `err` and is not forwarded.

## Timing
- Reset values:
  - state IDLE, `rr_ptr`=0, `gnt_id`=0, config registers 0, counters 0, `err`=0.
  - `req_ready`=0, `eu_en`=0, `eu_din`=0, `out_valid`=0, `out_last`=0.
  - `eu_rst`=0 while `rst`=1, so `eu_rst = ~(rst | state==LOAD)`.
- `req_ready`, `eu_en`, `eu_din` and all `out_*` are combinational from state and inputs. Configuration outputs are registered.
- Grant latency: `req_valid` in IDLE at cycle t → LOAD at t+1 → first `req_ready` at t+2.
- Session overhead: 1 (IDLE) + 1 (LOAD) + PIPE_LAT drain cycles.
- Reset mid-session: the session is abandoned, the encrypt unit is reset, in-flight results are suppressed because `outstanding` is 0, and `err` is not set.

## Structure
- `encrypt_config` package gains:
  - `enc_cfg_t`, a packed struct: k1, k2, k3, rot_freq, shift_en, shift_amt, mode (32 bits).
  - `sched_state_t`, an enum: IDLE, LOAD, BURST, DRAIN.
  - `SCHED_MAX_BURST` constant.
- Sub-module `rr_arbiter`: `NREQ` request bits plus pointer → one-hot grant and encoded ID. Purely combinational.
- The scheduler instantiates `rr_arbiter` only; `encrypt_unit` is instantiated beside it at the level above.

## Test plan
- Single requester, 3 bytes 0x11/0x22/0x33 with last: `req_ready` first high 2 cycles after `req_valid`. Three `out_valid` appear with `out_id`=0, `out_last` only on the third, and data matches the golden model from a fresh key.
- Both requesters valid at reset release: req0 is served first, then req1. Results never interleave, `rr_ptr` alternates, and each session is preceded by exactly one `eu_rst`=0 cycle.
- 20-byte stream with MAX_BURST=16: `out_last` on byte 16, LOAD re-entered, and bytes 17–20 are encrypted from a fresh key.
- `req_valid` gaps of 3 cycles mid-burst: `eu_en` pulses only on handshakes, outputs stay in order, and `outstanding` never exceeds PIPE_LAT.
- `rst` asserted during BURST with 2 bytes in flight: no `out_valid`, state IDLE, `err`=0. A subsequent session encrypts correctly.
- Spurious `eu_v` injected in IDLE: `err` rises and stays set until `rst`; `out_valid` stays 0.
